// File: rtl/ram_access_ctrl_if.sv
// CPU-side request/response bundle for ram_access_ctrl.
// The master issues load/store requests and consumes read responses.
interface ram_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_address, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_address, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// In-order request sequencer and sole master of a negedge-sampled data RAM.
// Queues CPU requests, issues one-cycle RAM accesses, returns reads with backpressure.
module ram_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  ram_access_ctrl_if.slave             bus,
  output logic [ADDR_WIDTH-1:0]        ram_address,
  output logic [DATA_WIDTH-1:0]        ram_data_in,
  output logic                         ram_we,
  output logic                         ram_chip_select,
  input  logic [DATA_WIDTH-1:0]        ram_data_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                  fifo_mem [FIFO_DEPTH];
  req_t                  head;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [1:0]            state;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  push;
  logic                  pop;

  // Ready comes from the registered count only, so a full FIFO never takes a push
  // even when the head is being popped in the same cycle.
  assign bus.req_ready = (fifo_count != CW'(FIFO_DEPTH)) && !reset;
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == IDLE) && (fifo_count != '0);
  assign head          = fifo_mem[rd_ptr];
  assign busy          = (state != IDLE) || (fifo_count != '0);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;

  // NOTE: storage is not reset; the pointers and count decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{we: bus.req_we, address: bus.req_address, data: bus.req_data};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, matching the hardware it describes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      ram_address     <= '0;
      ram_data_in     <= '0;
      ram_we          <= 1'b0;
      ram_chip_select <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            ram_address     <= head.address;
            ram_we          <= head.we;
            ram_data_in     <= head.data;
            ram_chip_select <= 1'b1;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM acted on the negedge inside this cycle, so its output is settled here.
          ram_chip_select <= 1'b0;
          ram_we          <= 1'b0;
          if (ram_we) begin
            state <= IDLE;
          end else begin
            rsp_data  <= ram_data_out;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
